// File: rtl/generador_codigo_gray.sv
// Registered Gray-code sequence generator with valid/ready output and binary preload.
// Optional macro GRAY_PARITY_EN: registers paridad = ^g alongside g; otherwise paridad is tied low.
module generador_codigo_gray #(
  parameter int WIDTH = 4
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic             habilitar,
  input  logic             direccion,
  input  logic             modo_ciclico,
  input  logic             cargar,
  input  logic [WIDTH-1:0] dato_carga,
  input  logic             g_listo,
  output logic [WIDTH-1:0] g,
  output logic             g_valido,
  output logic             fin,
  output logic             paridad
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_VALIDO = 2'd1;
  localparam logic [1:0] S_FIN    = 2'd2;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_UNO = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       estado, estado_sig;
  logic [WIDTH-1:0] cnt, cnt_sig;
  logic             fin_sig;
  logic             xfer;
  logic             terminal;

  function automatic logic [WIDTH-1:0] a_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign xfer     = g_valido & g_listo;
  assign terminal = direccion ? (cnt == CNT_MAX) : (cnt == '0);

  // Load flushes whatever is pending; a stalled transfer never moves cnt.
  always_comb begin
    estado_sig = estado;
    cnt_sig    = cnt;
    fin_sig    = 1'b0;
    if (cargar) begin
      cnt_sig    = dato_carga;
      estado_sig = habilitar ? S_VALIDO : S_IDLE;
    end else begin
      case (estado)
        S_IDLE: begin
          if (habilitar) estado_sig = S_VALIDO;
        end
        S_VALIDO: begin
          if (xfer) begin
            fin_sig = terminal;
            if (terminal && !modo_ciclico) begin
              estado_sig = S_FIN;
            end else begin
              cnt_sig    = direccion ? (cnt + CNT_UNO) : (cnt - CNT_UNO);
              estado_sig = habilitar ? S_VALIDO : S_IDLE;
            end
          end
        end
        S_FIN:   estado_sig = S_FIN;
        default: estado_sig = S_IDLE;
      endcase
    end
  end

  // Output register stage: g and g_valido follow the next-state values.
  always_ff @(posedge reloj) begin
    if (!reset) begin
      estado   <= S_IDLE;
      cnt      <= '0;
      g        <= '0;
      g_valido <= 1'b0;
      fin      <= 1'b0;
    end else begin
      estado   <= estado_sig;
      cnt      <= cnt_sig;
      g        <= a_gray(cnt_sig);
      g_valido <= (estado_sig == S_VALIDO);
      fin      <= fin_sig;
    end
  end

`ifdef GRAY_PARITY_EN
  always_ff @(posedge reloj) begin
    if (!reset) paridad <= 1'b0;
    else        paridad <= ^a_gray(cnt_sig);
  end
`else
  assign paridad = 1'b0;
`endif

endmodule

// File: tb/tb_generador_codigo_gray.sv
// Self-checking bench for generador_codigo_gray: directed scenarios plus randomized run
// against a behavioural counter model.
module tb_generador_codigo_gray;

  localparam int W    = 4;
  localparam int MODV = 1 << W;

  logic         reloj = 1'b0;
  logic         reset = 1'b0;
  logic         habilitar = 1'b0;
  logic         direccion = 1'b1;
  logic         modo_ciclico = 1'b1;
  logic         cargar = 1'b0;
  logic [W-1:0] dato_carga = '0;
  logic         g_listo = 1'b0;
  logic [W-1:0] g;
  logic         g_valido;
  logic         fin;
  logic         paridad;

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain integer counter plus "presenting" / "halted" flags.
  int m_cnt  = 0;
  bit m_valid = 1'b0;
  bit m_halt  = 1'b0;
  bit m_fin   = 1'b0;

  always #5 reloj = ~reloj;

  generador_codigo_gray #(.WIDTH(W)) dut (
    .reloj(reloj), .reset(reset), .habilitar(habilitar), .direccion(direccion),
    .modo_ciclico(modo_ciclico), .cargar(cargar), .dato_carga(dato_carga),
    .g_listo(g_listo), .g(g), .g_valido(g_valido), .fin(fin), .paridad(paridad)
  );

  function automatic int gray_of(int n);
    return n ^ (n / 2);
  endfunction

  function automatic bit par_of(int code);
`ifdef GRAY_PARITY_EN
    return 1'($countones(code) % 2);
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model with the inputs currently applied, then clock the DUT.
  task automatic tick();
    bit term;
    if (!reset) begin
      m_cnt = 0; m_valid = 1'b0; m_halt = 1'b0; m_fin = 1'b0;
    end else if (cargar) begin
      m_cnt = int'(dato_carga); m_valid = habilitar; m_halt = 1'b0; m_fin = 1'b0;
    end else if (m_halt) begin
      m_fin = 1'b0;
    end else if (!m_valid) begin
      m_valid = habilitar; m_fin = 1'b0;
    end else if (g_listo) begin
      term  = direccion ? (m_cnt == MODV - 1) : (m_cnt == 0);
      m_fin = term;
      if (term && !modo_ciclico) begin
        m_halt = 1'b1; m_valid = 1'b0;
      end else begin
        m_cnt   = direccion ? (m_cnt + 1) % MODV : (m_cnt + MODV - 1) % MODV;
        m_valid = habilitar;
      end
    end else begin
      m_fin = 1'b0;
    end
    @(posedge reloj);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (g !== '0)         begin errors++; $display("FAIL reset_g got %0h want 0", g); end
    checks++; if (g_valido !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", g_valido); end
    checks++; if (fin !== 1'b0)      begin errors++; $display("FAIL reset_fin got %0b want 0", fin); end
    checks++; if (paridad !== 1'b0)  begin errors++; $display("FAIL reset_paridad got %0b want 0", paridad); end
  endtask

  task automatic test_up_cyclic();
    int exp_up [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    reset = 1'b1; habilitar = 1'b1; g_listo = 1'b1; direccion = 1'b1; modo_ciclico = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      checks++;
      if (g !== W'(exp_up[k]) || g_valido !== 1'b1) begin
        errors++; $display("FAIL up_seq[%0d] got g=%0h v=%0b want g=%0h v=1", k, g, g_valido, exp_up[k]);
      end
      checks++;
      if (fin !== (k == 16)) begin
        errors++; $display("FAIL up_fin[%0d] got %0b want %0b", k, fin, (k == 16));
      end
      checks++;
      if (paridad !== par_of(exp_up[k])) begin
        errors++; $display("FAIL up_paridad[%0d] got %0b want %0b", k, paridad, par_of(exp_up[k]));
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 4; k++) tick();
    checks++; if (g !== 4'h6) begin errors++; $display("FAIL stall_pre got %0h want 6", g); end
    g_listo = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) direccion = 1'b0;
      habilitar = 1'(i % 2);
      tick();
      checks++;
      if (g !== 4'h6 || g_valido !== 1'b1 || fin !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d] got g=%0h v=%0b f=%0b want g=6 v=1 f=0", i, g, g_valido, fin);
      end
    end
    direccion = 1'b1; habilitar = 1'b1; g_listo = 1'b1;
    tick();
    checks++; if (g !== 4'h7 || g_valido !== 1'b1) begin errors++; $display("FAIL stall_resume got g=%0h v=%0b want g=7 v=1", g, g_valido); end
  endtask

  task automatic test_load_down();
    int exp_dn [5] = '{6, 2, 3, 1, 0};
    cargar = 1'b1; dato_carga = 4'd5; direccion = 1'b0; modo_ciclico = 1'b0;
    habilitar = 1'b1; g_listo = 1'b1;
    tick();
    cargar = 1'b0;
    checks++;
    if (g !== 4'h7 || g_valido !== 1'b1 || fin !== 1'b0) begin
      errors++; $display("FAIL load5 got g=%0h v=%0b f=%0b want g=7 v=1 f=0", g, g_valido, fin);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (g !== W'(exp_dn[k]) || g_valido !== 1'b1 || fin !== 1'b0) begin
        errors++; $display("FAIL down_seq[%0d] got g=%0h v=%0b f=%0b want g=%0h v=1 f=0", k, g, g_valido, fin, exp_dn[k]);
      end
    end
    tick();
    checks++;
    if (fin !== 1'b1 || g_valido !== 1'b0 || g !== 4'h0) begin
      errors++; $display("FAIL down_fin got g=%0h v=%0b f=%0b want g=0 v=0 f=1", g, g_valido, fin);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (g_valido !== 1'b0 || fin !== 1'b0 || g !== 4'h0) begin
        errors++; $display("FAIL halted[%0d] got g=%0h v=%0b f=%0b want g=0 v=0 f=0", k, g, g_valido, fin);
      end
    end
  endtask

  task automatic test_load_flush();
    cargar = 1'b1; dato_carga = 4'd2; direccion = 1'b1; modo_ciclico = 1'b1;
    habilitar = 1'b1; g_listo = 1'b0;
    tick();
    checks++; if (g !== 4'h3 || g_valido !== 1'b1) begin errors++; $display("FAIL flush_pre got g=%0h v=%0b want g=3 v=1", g, g_valido); end
    g_listo = 1'b1; dato_carga = 4'd10;
    tick();
    checks++;
    if (g !== 4'hF || fin !== 1'b0 || g_valido !== 1'b1) begin
      errors++; $display("FAIL flush_load got g=%0h v=%0b f=%0b want g=F v=1 f=0", g, g_valido, fin);
    end
    cargar = 1'b0;
    tick();
    checks++; if (g !== 4'hE) begin errors++; $display("FAIL flush_next got %0h want E", g); end
    cargar = 1'b1; dato_carga = 4'd15; g_listo = 1'b0;
    tick();
    checks++; if (g !== 4'h8) begin errors++; $display("FAIL load15 got %0h want 8", g); end
    dato_carga = 4'd3; g_listo = 1'b1;
    tick();
    checks++;
    if (g !== 4'h2 || fin !== 1'b0) begin
      errors++; $display("FAIL flush_term got g=%0h f=%0b want g=2 f=0", g, fin);
    end
    cargar = 1'b0;
  endtask

  task automatic test_reset_mid();
    g_listo = 1'b0; habilitar = 1'b1;
    tick();
    checks++; if (g_valido !== 1'b1) begin errors++; $display("FAIL rstmid_pre got v=%0b want 1", g_valido); end
    reset = 1'b0;
    tick();
    checks++;
    if (g !== '0 || g_valido !== 1'b0 || fin !== 1'b0 || paridad !== 1'b0) begin
      errors++; $display("FAIL rstmid got g=%0h v=%0b f=%0b p=%0b want 0 0 0 0", g, g_valido, fin, paridad);
    end
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic [W-1:0] prev_g;
    bit           clean;
    int           exp_g;
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 99) != 0);
      cargar       = ($urandom_range(0, 19) == 0);
      dato_carga   = W'($urandom);
      habilitar    = ($urandom_range(0, 3) != 0);
      g_listo      = ($urandom_range(0, 2) != 0);
      direccion    = 1'($urandom_range(0, 1));
      modo_ciclico = ($urandom_range(0, 3) != 0);
      clean        = reset && !cargar;
      prev_g       = g;
      tick();
      exp_g = gray_of(m_cnt);
      checks++;
      if (g !== W'(exp_g) || g_valido !== m_valid || fin !== m_fin || paridad !== par_of(exp_g)) begin
        errors++;
        $display("FAIL rand[%0d] got g=%0h v=%0b f=%0b p=%0b want g=%0h v=%0b f=%0b p=%0b",
                 i, g, g_valido, fin, paridad, exp_g, m_valid, m_fin, par_of(exp_g));
      end
      if (clean && g !== prev_g) begin
        checks++;
        if ($countones(g ^ prev_g) != 1) begin
          errors++; $display("FAIL rand_onebit[%0d] got %0h->%0h want single-bit change", i, prev_g, g);
        end
      end
    end
    reset = 1'b1; cargar = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_cyclic();
    test_stall();
    test_load_down();
    test_load_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/generador_codigo_gray.md
# generador_codigo_gray

Registered Gray-code sequence generator with a valid/ready output handshake. It sits directly upstream of the Gray-to-binary decoder and drives its `g` input with one Gray code per accepted transfer. It counts up or down in binary internally, runs cyclic or single-shot, and accepts a binary preload.

## Interface

Parameters:
- WIDTH, 4, code width in bits; legal range 2..16; the default matches the decoder input.

Ports:
- reloj  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising edge of reloj.
- habilitar  in  1  run request; permits emission/advance.
- direccion  in  1  1 = count up, 0 = count down; sampled only at a step.
- modo_ciclico  in  1  1 = wrap at terminal, 0 = stop after terminal.
- cargar  in  1  load request; highest priority after reset.
- dato_carga  in  WIDTH  binary value to load.
- g_listo  in  1  consumer ready.
- g  out  WIDTH  registered Gray code, g = cnt ^ (cnt >> 1).
- g_valido  out  1  g holds a valid code.
- fin  out  1  one-cycle pulse: the terminal code was transferred.
- paridad  out  1  XOR of g bits (see Configuration).

## Operation

- Internal binary counter cnt[WIDTH-1:0]. g is always registered Gray(cnt).
- Transfer (xfer) = g_valido & g_listo.
- Terminal value: 2^WIDTH-1 when direccion=1, 0 when direccion=0. Evaluated against the current cnt and direccion.
- States: S_IDLE (g_valido=0), S_VALIDO (g_valido=1), S_FIN (g_valido=0, halted).
- S_IDLE:
  - habilitar=1 -> S_VALIDO. The current cnt is presented without stepping.
  - Otherwise hold.
- S_VALIDO, no xfer: hold g/cnt stable regardless of habilitar and direccion. Stall-safe; a dropped habilitar never retracts valid.
- S_VALIDO, xfer, at terminal:
  - fin=1 next cycle.
  - modo_ciclico=1: wrap (15->0 up, 0->15 down for WIDTH=4). Stay in S_VALIDO if habilitar=1, else step and go to S_IDLE.
  - modo_ciclico=0: cnt unchanged, go to S_FIN.
- S_VALIDO, xfer, not terminal: cnt +/- 1 per direccion. Stay in S_VALIDO if habilitar=1, else step and go to S_IDLE.
- S_FIN: ignores habilitar. Leaves only on cargar or reset.
- cargar=1 in any state:
  - cnt <= dato_carga; g <= Gray(dato_carga).
  - Next state S_VALIDO if habilitar=1, else S_IDLE.
  - fin=0 that cycle.
  - Overrides any simultaneous xfer/step; the pending code is discarded (flush semantics).
- Arithmetic is modulo 2^WIDTH; no carry out.

## Timing

- All outputs are registered; there is no combinational input->output path.
- Reset (reset=0 at edge): cnt=0, g=0, g_valido=0, fin=0, paridad=0, state S_IDLE. Reset mid-transfer aborts; the bus shows valid=0 the next cycle.
- Latency: habilitar in S_IDLE -> g_valido=1 on the next edge. cargar -> new g on the next edge.
- Sustained throughput with habilitar=1 and g_listo=1: one new code per cycle. Consecutive codes differ in exactly one bit, except across a load.
- fin asserts the cycle after the xfer of the terminal code, for exactly one cycle.
- direccion change while stalled takes effect at the next step only; the held g does not change.

## Configuration

- GRAY_PARITY_EN defined: paridad is registered with g and equals ^g. It toggles on every single-step advance and updates on load.
- GRAY_PARITY_EN undefined: no parity logic; paridad is tied to 0. The port is always present.

## Test plan

- Reset, then habilitar=1, g_listo=1, direccion=1, modo_ciclico=1 for 17 cycles -> g = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. fin pulses once, one cycle after g=8 transfers.
- Mid-stream g_listo=0 for 5 cycles with g=6 -> g stays 6, g_valido stays 1; sequence resumes with 7 after g_listo=1.
- cargar=1, dato_carga=5, direccion=0, modo_ciclico=0, run -> g = 7,6,2,3,1,0. fin after 0 transfers. State S_FIN, g_valido=0; habilitar ignored until the next cargar.
- cargar=1 with simultaneous xfer at g=3 and dato_carga=10 -> next g=F (Gray of 10); no step; fin=0.
- reset=0 asserted while g_valido=1 and g_listo=0 -> next cycle g=0, g_valido=0, fin=0.
- With GRAY_PARITY_EN, an up-count from 0 -> paridad = 0,1,0,1,... One build without the macro -> paridad constant 0.
